// File: rtl/rs_array_if.sv
// rtl/rs_array_if.sv - issue, CDB, dispatch and completion bundle for the reservation station
interface rs_array_if #(
    parameter int ENTRIES = 4,
    parameter int DW      = 32,
    parameter int TAGW    = 4,
    parameter int OPW     = 3,
    parameter int IDXW    = $clog2(ENTRIES)
);
    logic                issue_valid;
    logic                issue_ready;
    logic [OPW-1:0]      issue_op;
    logic [DW-1:0]       issue_vj;
    logic [TAGW-1:0]     issue_qj;
    logic [DW-1:0]       issue_vk;
    logic [TAGW-1:0]     issue_qk;
    logic [IDXW-1:0]     issue_idx;

    logic                cdb_valid;
    logic [TAGW-1:0]     cdb_tag;
    logic [DW-1:0]       cdb_data;

    logic                disp_valid;
    logic                disp_ready;
    logic [OPW-1:0]      disp_op;
    logic [DW-1:0]       disp_vj;
    logic [DW-1:0]       disp_vk;
    logic [IDXW-1:0]     disp_idx;

    logic                done_valid;
    logic [IDXW-1:0]     done_idx;
    logic [ENTRIES-1:0]  busy;
    logic [IDXW:0]       busy_cnt;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, disp_ready,
        input  issue_ready, issue_idx, disp_valid, disp_op, disp_vj, disp_vk, disp_idx,
        input  done_valid, done_idx, busy, busy_cnt
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, disp_ready,
        output issue_ready, issue_idx, disp_valid, disp_op, disp_vj, disp_vk, disp_idx,
        output done_valid, done_idx, busy, busy_cnt
    );
endinterface

// File: rtl/rs_array.sv
// rtl/rs_array.sv - multi-entry Tomasulo reservation station with CDB snoop and execution countdown
module rs_array #(
    parameter int ENTRIES = 4,
    parameter int DW      = 32,
    parameter int TAGW    = 4,
    parameter int OPW     = 3,
    parameter int EXE_LAT = 2,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic      clk,
    input  logic      rst,
    rs_array_if.slave io
);
    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    logic [1:0]      state_q [ENTRIES];
    logic [1:0]      state_d [ENTRIES];
    logic [OPW-1:0]  op_q    [ENTRIES];
    logic [OPW-1:0]  op_d    [ENTRIES];
    logic [DW-1:0]   vj_q    [ENTRIES];
    logic [DW-1:0]   vj_d    [ENTRIES];
    logic [DW-1:0]   vk_q    [ENTRIES];
    logic [DW-1:0]   vk_d    [ENTRIES];
    logic [TAGW-1:0] qj_q    [ENTRIES];
    logic [TAGW-1:0] qj_d    [ENTRIES];
    logic [TAGW-1:0] qk_q    [ENTRIES];
    logic [TAGW-1:0] qk_d    [ENTRIES];
    logic [3:0]      timer_q [ENTRIES];
    logic [3:0]      timer_d [ENTRIES];

    logic            done_valid_q;
    logic            done_valid_d;
    logic [IDXW-1:0] done_idx_q;
    logic [IDXW-1:0] done_idx_d;

    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic            rdy_found;
    logic [IDXW-1:0] rdy_idx;
    logic            issue_fire;
    logic            disp_fire;

    logic [DW-1:0]   cap_vj;
    logic [DW-1:0]   cap_vk;
    logic [TAGW-1:0] cap_qj;
    logic [TAGW-1:0] cap_qk;

    logic [ENTRIES-1:0] busy_vec;
    logic [IDXW:0]      busy_sum;

    // Lowest-index FREE entry takes the next issue; lowest-index READY entry dispatches.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!free_found && state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
            if (!rdy_found && state_q[i] == ST_READY) begin
                rdy_found = 1'b1;
                rdy_idx   = IDXW'(i);
            end
        end
    end

    assign issue_fire = io.issue_valid && free_found;
    assign disp_fire  = rdy_found && io.disp_ready;

    // Operand capture at issue, including a same-cycle CDB bypass.
    always_comb begin
        cap_vj = io.issue_vj;
        cap_qj = '0;
        if (io.issue_qj != '0) begin
            if (io.cdb_valid && io.cdb_tag == io.issue_qj) begin
                cap_vj = io.cdb_data;
            end else begin
                cap_vj = '0;
                cap_qj = io.issue_qj;
            end
        end
        cap_vk = io.issue_vk;
        cap_qk = '0;
        if (io.issue_qk != '0) begin
            if (io.cdb_valid && io.cdb_tag == io.issue_qk) begin
                cap_vk = io.cdb_data;
            end else begin
                cap_vk = '0;
                cap_qk = io.issue_qk;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (issue_fire && free_idx == IDXW'(i)) begin
                        op_d[i]    = io.issue_op;
                        vj_d[i]    = cap_vj;
                        vk_d[i]    = cap_vk;
                        qj_d[i]    = cap_qj;
                        qk_d[i]    = cap_qk;
                        state_d[i] = (cap_qj == '0 && cap_qk == '0) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io.cdb_valid && qj_q[i] != '0 && qj_q[i] == io.cdb_tag) begin
                        vj_d[i] = io.cdb_data;
                        qj_d[i] = '0;
                    end
                    if (io.cdb_valid && qk_q[i] != '0 && qk_q[i] == io.cdb_tag) begin
                        vk_d[i] = io.cdb_data;
                        qk_d[i] = '0;
                    end
                    if (qj_d[i] == '0 && qk_d[i] == '0) begin
                        state_d[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (disp_fire && rdy_idx == IDXW'(i)) begin
                        state_d[i] = ST_EXEC;
                        timer_d[i] = 4'(EXE_LAT);
                    end
                end
                default: begin
                    if (timer_q[i] == 4'd0) begin
                        state_d[i] = ST_FREE;
                        op_d[i]    = '0;
                        vj_d[i]    = '0;
                        vk_d[i]    = '0;
                        qj_d[i]    = '0;
                        qk_d[i]    = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - 4'd1;
                    end
                end
            endcase
        end
    end

    // Completion is registered one edge ahead so it lines up with the timer==0 cycle.
    always_comb begin
        done_valid_d = 1'b0;
        done_idx_d   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_q[i] == ST_EXEC && timer_q[i] == 4'd1) begin
                done_valid_d = 1'b1;
                done_idx_d   = IDXW'(i);
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        busy_sum = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i] = (state_q[i] != ST_FREE);
            busy_sum    = busy_sum + (IDXW+1)'(busy_vec[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                timer_q[i] <= '0;
            end
            done_valid_q <= 1'b0;
            done_idx_q   <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
                timer_q[i] <= timer_d[i];
            end
            done_valid_q <= done_valid_d;
            done_idx_q   <= done_idx_d;
        end
    end

    assign io.issue_ready = free_found;
    assign io.issue_idx   = free_idx;
    assign io.disp_valid  = rdy_found;
    assign io.disp_op     = rdy_found ? op_q[rdy_idx] : '0;
    assign io.disp_vj     = rdy_found ? vj_q[rdy_idx] : '0;
    assign io.disp_vk     = rdy_found ? vk_q[rdy_idx] : '0;
    assign io.disp_idx    = rdy_idx;
    assign io.done_valid  = done_valid_q;
    assign io.done_idx    = done_idx_q;
    assign io.busy        = busy_vec;
    assign io.busy_cnt    = busy_sum;
endmodule

// File: tb/tb_rs_array.sv
// tb/tb_rs_array.sv - scoreboard bench for the reservation station
module tb_rs_array;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_array_if bus ();
    rs_array dut (.clk(clk), .rst(rst), .io(bus.slave));

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [1:0]  idx;
    } disp_t;

    disp_t exp_q[$];
    int    done_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_op    = '0;
        bus.issue_vj    = '0;
        bus.issue_qj    = '0;
        bus.issue_vk    = '0;
        bus.issue_qk    = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.disp_ready  = 1'b0;
    endtask

    task automatic set_issue(input logic [2:0] op, input logic [31:0] vj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic [3:0] qk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_vj    = vj;
        bus.issue_qj    = qj;
        bus.issue_vk    = vk;
        bus.issue_qk    = qk;
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [1:0] idx);
        disp_t e;
        e.op = op; e.vj = vj; e.vk = vk; e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        bus.cdb_valid  = 1'b0;
        bus.disp_ready = 1'b1;
        while (bus.busy !== 4'b0 && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (bus.busy_cnt !== 3'd0) $display("FAIL drain: busy_cnt=%0d expected 0 after %0d cycles", bus.busy_cnt, n);
        else pass_cnt++;
        bus.disp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.issue_ready !== 1'b1 || bus.disp_valid !== 1'b0 || bus.done_valid !== 1'b0)
            $display("FAIL reset_ctl: ready=%b disp_valid=%b done_valid=%b expected 1 0 0", bus.issue_ready, bus.disp_valid, bus.done_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 4'b0 || bus.busy_cnt !== 3'd0)
            $display("FAIL reset_busy: busy=%b cnt=%0d expected 0000 0", bus.busy, bus.busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.disp_op !== 3'd0 || bus.disp_vj !== 32'd0 || bus.disp_vk !== 32'd0 || bus.disp_idx !== 2'd0 || bus.done_idx !== 2'd0)
            $display("FAIL reset_data: op=%0d vj=%h vk=%h idx=%0d done_idx=%0d expected all 0", bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_idx, bus.done_idx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec();
        int pulses = 0;
        idle();
        bus.disp_ready = 1'b1;
        set_issue(3'd3, 32'd5, 4'd0, 32'd7, 4'd0);
        tick();
        bus.issue_valid = 1'b0;
        total_cnt++;
        if (bus.disp_valid !== 1'b1) $display("FAIL rme_ready: disp_valid=%b expected 1", bus.disp_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.busy_cnt !== 3'd1) $display("FAIL rme_exec: busy_cnt=%0d expected 1", bus.busy_cnt);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.busy !== 4'b0 || bus.issue_ready !== 1'b1)
            $display("FAIL rme_async: busy=%b issue_ready=%b expected 0000 1", bus.busy, bus.issue_ready);
        else pass_cnt++;
        repeat (2) begin
            tick();
            if (bus.done_valid === 1'b1) pulses++;
        end
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (bus.done_valid === 1'b1) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL rme_done: done pulses=%0d expected 0", pulses);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_ready_issue();
        disp_t e;
        idle();
        bus.disp_ready = 1'b1;
        set_issue(3'd1, 32'h10, 4'd0, 32'h20, 4'd0);
        push_exp(3'd1, 32'h10, 32'h20, 2'd0);
        tick();
        bus.issue_valid = 1'b0;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.disp_valid !== 1'b1 || bus.disp_idx !== e.idx || bus.disp_op !== e.op || bus.disp_vj !== e.vj || bus.disp_vk !== e.vk)
            $display("FAIL ri_disp: valid=%b idx=%0d op=%0d vj=%h vk=%h expected 1 %0d %0d %h %h",
                     bus.disp_valid, bus.disp_idx, bus.disp_op, bus.disp_vj, bus.disp_vk, e.idx, e.op, e.vj, e.vk);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus.done_valid !== 1'b0) $display("FAIL ri_early: done_valid=%b expected 0 at cycle 3", bus.done_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done_valid !== 1'b1 || bus.done_idx !== 2'd0)
            $display("FAIL ri_done: done_valid=%b done_idx=%0d expected 1 0", bus.done_valid, bus.done_idx);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done_valid !== 1'b0 || bus.busy_cnt !== 3'd0)
            $display("FAIL ri_free: done_valid=%b busy_cnt=%0d expected 0 0", bus.done_valid, bus.busy_cnt);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_cdb_wakeup();
        disp_t e;
        idle();
        bus.disp_ready = 1'b1;
        set_issue(3'd2, 32'h1111, 4'd5, 32'h2222, 4'd6);
        push_exp(3'd2, 32'hAA, 32'hBB, 2'd0);
        tick();
        bus.issue_valid = 1'b0;
        total_cnt++;
        if (bus.disp_valid !== 1'b0 || bus.busy_cnt !== 3'd1)
            $display("FAIL cw_wait: disp_valid=%b busy_cnt=%0d expected 0 1", bus.disp_valid, bus.busy_cnt);
        else pass_cnt++;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 32'hAA;
        tick();
        total_cnt++;
        if (bus.disp_valid !== 1'b0) $display("FAIL cw_half: disp_valid=%b expected 0", bus.disp_valid);
        else pass_cnt++;
        bus.cdb_tag = 4'd6; bus.cdb_data = 32'hBB;
        tick();
        bus.cdb_valid = 1'b0;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.disp_valid !== 1'b1 || bus.disp_idx !== e.idx || bus.disp_op !== e.op || bus.disp_vj !== e.vj || bus.disp_vk !== e.vk)
            $display("FAIL cw_disp: valid=%b idx=%0d op=%0d vj=%h vk=%h expected 1 %0d %0d %h %h",
                     bus.disp_valid, bus.disp_idx, bus.disp_op, bus.disp_vj, bus.disp_vk, e.idx, e.op, e.vj, e.vk);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_bypass();
        disp_t e;
        idle();
        set_issue(3'd5, 32'h999, 4'd9, 32'h66, 4'd0);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'h55;
        push_exp(3'd5, 32'h55, 32'h66, 2'd0);
        tick();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        e = exp_q.pop_front();
        total_cnt++;
        if (bus.disp_valid !== 1'b1 || bus.disp_idx !== e.idx || bus.disp_op !== e.op || bus.disp_vj !== e.vj || bus.disp_vk !== e.vk)
            $display("FAIL bp_disp: valid=%b idx=%0d op=%0d vj=%h vk=%h expected 1 %0d %0d %h %h",
                     bus.disp_valid, bus.disp_idx, bus.disp_op, bus.disp_vj, bus.disp_vk, e.idx, e.op, e.vj, e.vk);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_full_priority();
        disp_t e;
        int    d;
        idle();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus.issue_ready !== 1'b1 || bus.issue_idx !== 2'(i))
                $display("FAIL fp_issue: ready=%b idx=%0d expected 1 %0d", bus.issue_ready, bus.issue_idx, i);
            else pass_cnt++;
            set_issue(3'(i + 1), 32'h100 + i, 4'd3, 32'h200 + i, 4'd0);
            push_exp(3'(i + 1), 32'hC3, 32'h200 + i, 2'(i));
            tick();
        end
        set_issue(3'd7, 32'hDEAD, 4'd0, 32'hBEEF, 4'd0);
        tick();
        bus.issue_valid = 1'b0;
        total_cnt++;
        if (bus.issue_ready !== 1'b0 || bus.busy_cnt !== 3'd4 || bus.disp_valid !== 1'b0)
            $display("FAIL fp_full: ready=%b busy_cnt=%0d disp_valid=%b expected 0 4 0", bus.issue_ready, bus.busy_cnt, bus.disp_valid);
        else pass_cnt++;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_data = 32'hC3;
        tick();
        bus.cdb_valid  = 1'b0;
        bus.disp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.done_valid === 1'b1 && done_q.size() > 0) begin
                d = done_q.pop_front();
                total_cnt++;
                if (bus.done_idx !== 2'(d)) $display("FAIL fp_done: done_idx=%0d expected %0d", bus.done_idx, d);
                else pass_cnt++;
            end
            e = exp_q.pop_front();
            total_cnt++;
            if (bus.disp_valid !== 1'b1 || bus.disp_idx !== e.idx || bus.disp_op !== e.op || bus.disp_vj !== e.vj || bus.disp_vk !== e.vk)
                $display("FAIL fp_disp%0d: valid=%b idx=%0d op=%0d vj=%h vk=%h expected 1 %0d %0d %h %h", k,
                         bus.disp_valid, bus.disp_idx, bus.disp_op, bus.disp_vj, bus.disp_vk, e.idx, e.op, e.vj, e.vk);
            else pass_cnt++;
            done_q.push_back(int'(e.idx));
            tick();
        end
        for (int c = 0; c < 10 && done_q.size() > 0; c++) begin
            if (bus.done_valid === 1'b1) begin
                d = done_q.pop_front();
                total_cnt++;
                if (bus.done_idx !== 2'(d)) $display("FAIL fp_done: done_idx=%0d expected %0d", bus.done_idx, d);
                else pass_cnt++;
            end
            tick();
        end
        total_cnt++;
        if (done_q.size() !== 0) $display("FAIL fp_done_cnt: %0d completions missing expected 0", done_q.size());
        else pass_cnt++;
        done_q.delete();
        drain();
    endtask

    task automatic test_backpressure();
        disp_t e;
        idle();
        set_issue(3'd2, 32'h0, 4'd7, 32'h11, 4'd0);
        tick();
        set_issue(3'd4, 32'h22, 4'd0, 32'h0, 4'd7);
        tick();
        total_cnt++;
        if (bus.issue_idx !== 2'd2) $display("FAIL bk_idx: issue_idx=%0d expected 2", bus.issue_idx);
        else pass_cnt++;
        set_issue(3'd6, 32'h222, 4'd0, 32'h333, 4'd0);
        push_exp(3'd6, 32'h222, 32'h333, 2'd2);
        tick();
        bus.issue_valid = 1'b0;
        e = exp_q[0];
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (bus.disp_valid !== 1'b1 || bus.disp_idx !== e.idx || bus.disp_op !== e.op || bus.disp_vj !== e.vj || bus.disp_vk !== e.vk)
                $display("FAIL bk_hold%0d: valid=%b idx=%0d op=%0d vj=%h vk=%h expected 1 %0d %0d %h %h", k,
                         bus.disp_valid, bus.disp_idx, bus.disp_op, bus.disp_vj, bus.disp_vk, e.idx, e.op, e.vj, e.vk);
            else pass_cnt++;
            if (k < 2) tick();
        end
        void'(exp_q.pop_front());
        bus.disp_ready = 1'b1;
        tick();
        bus.disp_ready = 1'b0;
        total_cnt++;
        if (bus.disp_valid !== 1'b0 || bus.done_valid !== 1'b0)
            $display("FAIL bk_exec: disp_valid=%b done_valid=%b expected 0 0", bus.disp_valid, bus.done_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done_valid !== 1'b0) $display("FAIL bk_early: done_valid=%b expected 0", bus.done_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done_valid !== 1'b1 || bus.done_idx !== 2'd2)
            $display("FAIL bk_done: done_valid=%b done_idx=%0d expected 1 2", bus.done_valid, bus.done_idx);
        else pass_cnt++;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_data = 32'h77;
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_ready_issue();
        test_cdb_wakeup();
        test_bypass();
        test_full_priority();
        test_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
